alu_main: RTL and testbench



---
 rtl/alu_main.sv | 119 +++++++++++
 tb/tb_alu_main.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/alu_main.sv
// rtl/alu_main.sv - switch/LED board wrapper around a 6-bit registered ALU
// Optional OVF_LED_EN: implements the overflow register and drives led[6] from it.
module alu_main #(
    parameter int WIDTH = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic       en,
    output logic [7:0] led
);

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_F = 2'b10;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic [1:0]       sel;
    logic [WIDTH-1:0] data;
    logic             load_p;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       f_q, f_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             z_q, z_d;
    logic             en_d_q;

    logic [WIDTH-1:0] alu_y;

    assign sel    = sw[7:6];
    assign data   = sw[WIDTH-1:0];
    assign load_p = en & ~en_d_q;

    always_comb begin
        alu_y = '0;
        case (f_q)
            OP_ADD:  alu_y = a_q + b_q;
            OP_SUB:  alu_y = a_q - b_q;
            OP_AND:  alu_y = a_q & b_q;
            OP_OR:   alu_y = a_q | b_q;
            OP_XOR:  alu_y = a_q ^ b_q;
            OP_NOT:  alu_y = ~a_q;
            OP_SHL:  alu_y = a_q << 1;
            OP_SHR:  alu_y = a_q >> 1;
            default: alu_y = '0;
        endcase
    end

    // Operand registers only change on the rising edge of the debounced button.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        f_d = f_q;
        if (load_p) begin
            case (sel)
                SEL_A:   a_d = data;
                SEL_B:   b_d = data;
                SEL_F:   f_d = data[2:0];
                default: ;
            endcase
        end
        y_d = alu_y;
        z_d = (alu_y == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            f_q    <= '0;
            y_q    <= '0;
            z_q    <= 1'b0;
            en_d_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            f_q    <= f_d;
            y_q    <= y_d;
            z_q    <= z_d;
            en_d_q <= en;
        end
    end

`ifdef OVF_LED_EN
    logic ovf_q, ovf_d;

    // Signed overflow exists only for add and subtract.
    always_comb begin
        ovf_d = 1'b0;
        case (f_q)
            OP_ADD:  ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_y[WIDTH-1] != a_q[WIDTH-1]);
            OP_SUB:  ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_y[WIDTH-1] != a_q[WIDTH-1]);
            default: ovf_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign led = {z_q, ovf_q, y_q};
`else
    assign led = {z_q, 1'b0, y_q};
`endif

endmodule

// File: tb/tb_alu_main.sv
// tb/tb_alu_main.sv - self-checking bench for alu_main with an arithmetic reference model
module tb_alu_main;

`ifdef OVF_LED_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw  = 8'h00;
    logic       en  = 1'b0;
    logic [7:0] led;

    int total = 0;
    int bad   = 0;

    // reference state
    int       m_a = 0, m_b = 0, m_f = 0;
    bit       m_en_prev = 1'b0;
    bit [7:0] m_led = 8'h00;

    alu_main #(.WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw),
        .en  (en),
        .led (led)
    );

    always #5 clk = ~clk;

    function automatic int to_signed6(input int v);
        return (v >= 32) ? v - 64 : v;
    endfunction

    function automatic bit [7:0] ref_led(input int a, input int b, input int f);
        int y;
        int s;
        bit o;
        bit [7:0] r;
        y = 0;
        s = 0;
        o = 1'b0;
        case (f)
            0: begin y = (a + b) % 64;       s = to_signed6(a) + to_signed6(b); o = (s > 31) || (s < -32); end
            1: begin y = (a - b + 64) % 64;  s = to_signed6(a) - to_signed6(b); o = (s > 31) || (s < -32); end
            2: y = a & b;
            3: y = a | b;
            4: y = a ^ b;
            5: y = 63 - a;
            6: y = (a * 2) % 64;
            default: y = a / 2;
        endcase
        r[5:0] = y[5:0];
        r[6]   = OVF_ON && o;
        r[7]   = (y == 0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s led=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare at the falling edge.
    task automatic cyc(input string tag, input bit r, input logic [7:0] s, input bit e);
        rst = r;
        sw  = s;
        en  = e;
        @(posedge clk);
        if (r) begin
            m_a = 0; m_b = 0; m_f = 0;
            m_en_prev = 1'b0;
            m_led = 8'h00;
        end else begin
            m_led = ref_led(m_a, m_b, m_f);
            if (e && !m_en_prev) begin
                case (s[7:6])
                    2'b00: m_a = s[5:0];
                    2'b01: m_b = s[5:0];
                    2'b10: m_f = s[2:0];
                    default: ;
                endcase
            end
            m_en_prev = e;
        end
        @(negedge clk);
        check(tag, led, m_led);
    endtask

    task automatic load(input string tag, input logic [1:0] sel, input logic [5:0] d);
        cyc(tag, 1'b0, {sel, d}, 1'b1);
        cyc(tag, 1'b0, {sel, d}, 1'b0);
    endtask

    logic [7:0] held;

    initial begin
        @(negedge clk);
        // 1: reset state
        cyc("rst0", 1'b1, 8'h00, 1'b0);
        cyc("rst1", 1'b1, 8'h00, 1'b0);
        check("rst_led", led, 8'h00);
        cyc("post_rst", 1'b0, 8'h00, 1'b0);
        check("post_rst_zero", led, 8'h80);

        // 2: add then sub
        load("ldA5", 2'b00, 6'd5);
        load("ldB3", 2'b01, 6'd3);
        check("add_5_3", led, 8'h08);
        load("ldFsub", 2'b10, 6'd1);
        check("sub_5_3", led, 8'h02);

        // 3: held enable loads only on the rising cycle
        for (int i = 0; i < 5; i++) cyc("hold", 1'b0, {2'b00, 6'(10 + i)}, 1'b1);
        cyc("hold_rel", 1'b0, 8'h00, 1'b0);
        check("hold_first_only", led, 8'h07);

        // 4: signed overflow boundary
        load("ldFadd", 2'b10, 6'd0);
        load("ldA32", 2'b00, 6'd32);
        load("ldB32", 2'b01, 6'd32);
        check("ovf_32_32", led, OVF_ON ? 8'hC0 : 8'h80);

        // 5: sel=11 writes nothing
        held = led;
        for (int i = 0; i < 4; i++) load("sel11", 2'b11, 6'($urandom));
        check("sel11_unchanged", led, held);
        load("ldFand", 2'b10, 6'd2);
        load("ldA2A", 2'b00, 6'h2A);
        load("ldB0F", 2'b01, 6'h0F);
        check("and_2a_0f", led, 8'h0A);

        // 6: reset beats a simultaneous load
        cyc("rst_load", 1'b1, {2'b00, 6'd9}, 1'b1);
        check("rst_load_led", led, 8'h00);
        cyc("rst_load_after", 1'b0, {2'b00, 6'd9}, 1'b0);
        check("rst_load_a0", led, 8'h80);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc("rand", ($urandom_range(0, 59) == 0), 8'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
